// File: rtl/logic_op_pipe.sv
// logic_op_pipe: two-stage valid/ready pipeline computing AND/OR/XOR/NAND of a and b.
// Optional macro LOGIC_OP_PARITY_EN adds parity_out, a registered ^result.
module logic_op_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef LOGIC_OP_PARITY_EN
  output logic             parity_out,
`endif
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } opSel_e;

  logic             s1Valid_q, s1Valid_d;
  logic [WIDTH-1:0] s1A_q, s1A_d;
  logic [WIDTH-1:0] s1B_q, s1B_d;
  opSel_e           s1Op_q, s1Op_d;

  logic             s2Valid_q, s2Valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] count_q, count_d;
`ifdef LOGIC_OP_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             s2Adv;
  logic             inReady;
  logic             inFire;
  logic             outFire;
  logic [WIDTH-1:0] opResult;

  // S1 may move into S2 whenever S2 is empty or is being drained this cycle.
  always_comb begin
    s2Adv   = s1Valid_q & (~s2Valid_q | out_ready);
    inReady = ~s1Valid_q | s2Adv;
    inFire  = in_valid & inReady;
    outFire = s2Valid_q & out_ready;
  end

  always_comb begin
    opResult = '0;
    case (s1Op_q)
      OP_AND:  opResult = s1A_q & s1B_q;
      OP_OR:   opResult = s1A_q | s1B_q;
      OP_XOR:  opResult = s1A_q ^ s1B_q;
      OP_NAND: opResult = ~(s1A_q & s1B_q);
      default: opResult = '0;
    endcase
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1A_d     = s1A_q;
    s1B_d     = s1B_q;
    s1Op_d    = s1Op_q;
    s2Valid_d = s2Valid_q;
    result_d  = result_q;
    zero_d    = zero_q;
    count_d   = count_q;
`ifdef LOGIC_OP_PARITY_EN
    parity_d  = parity_q;
`endif

    if (inFire) begin
      s1Valid_d = 1'b1;
      s1A_d     = a;
      s1B_d     = b;
      s1Op_d    = opSel_e'(op);
    end else if (s2Adv) begin
      s1Valid_d = 1'b0;
    end

    // Result fields only load on advance, so they stay frozen while stalled.
    if (s2Adv) begin
      s2Valid_d = 1'b1;
      result_d  = opResult;
      zero_d    = ~|opResult;
`ifdef LOGIC_OP_PARITY_EN
      parity_d  = ^opResult;
`endif
    end else if (outFire) begin
      s2Valid_d = 1'b0;
    end

    if (outFire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Op_q    <= OP_AND;
      s2Valid_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      count_q   <= '0;
`ifdef LOGIC_OP_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      s1Valid_q <= s1Valid_d;
      s1A_q     <= s1A_d;
      s1B_q     <= s1B_d;
      s1Op_q    <= s1Op_d;
      s2Valid_q <= s2Valid_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      count_q   <= count_d;
`ifdef LOGIC_OP_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign in_ready   = inReady;
  assign out_valid  = s2Valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign xfer_count = count_q;
`ifdef LOGIC_OP_PARITY_EN
  assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: directed and random stimulus checked against a queue-based occupancy model.
// Honours LOGIC_OP_PARITY_EN when defined.
module tb_logic_op_pipe;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic [CW-1:0] xfer_count;
`ifdef LOGIC_OP_PARITY_EN
  logic          parity_out;
`endif

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
`ifdef LOGIC_OP_PARITY_EN
    .parity_out (parity_out),
`endif
    .xfer_count (xfer_count)
  );

  // Model: queue of beats still inside the block; inS2 marks the one on the output.
  typedef struct packed {
    logic [W-1:0] res;
    logic         inS2;
  } beat_t;

  beat_t pipeQ[$];
  int    expCount = 0;
  int    total = 0;
  int    bad   = 0;

  function automatic logic [W-1:0] refOp(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model at the edge.
  task automatic applyStimulus(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [1:0] opv, input logic orv);
    logic  expReady, expOutValid, inFire, outFire;
    beat_t nb;
    in_valid  = iv;
    a         = av;
    b         = bv;
    op        = opv;
    out_ready = orv;
    #1;
    expReady    = (pipeQ.size() < 2) || orv;
    expOutValid = (pipeQ.size() > 0) && pipeQ[0].inS2;
    checkOutput("in_ready", in_ready, expReady);
    checkOutput("out_valid", out_valid, expOutValid);
    if (expOutValid) begin
      checkOutput("result", result, pipeQ[0].res);
      checkOutput("zero", zero, pipeQ[0].res == '0);
`ifdef LOGIC_OP_PARITY_EN
      checkOutput("parity_out", parity_out, ^pipeQ[0].res);
`endif
    end
    checkOutput("xfer_count", xfer_count, expCount % (1 << CW));
    inFire  = iv && expReady;
    outFire = expOutValid && orv;
    @(posedge clk);
    if (outFire) begin
      void'(pipeQ.pop_front());
      expCount = (expCount + 1) % (1 << CW);
    end
    if (pipeQ.size() > 0 && !pipeQ[0].inS2) begin
      nb      = pipeQ[0];
      nb.inS2 = 1'b1;
      pipeQ[0] = nb;
    end
    if (inFire) begin
      nb.res  = refOp(av, bv, opv);
      nb.inS2 = 1'b0;
      pipeQ.push_back(nb);
    end
    @(negedge clk);
  endtask

  // Reset with a junk beat offered to show rst wins over transfers.
  task automatic doReset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 4'hF;
    b         = 4'hF;
    op        = 2'b01;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pipeQ.delete();
    expCount = 0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_result", result, 0);
    checkOutput("rst_zero", zero, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_xfer_count", xfer_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
`ifdef LOGIC_OP_PARITY_EN
    checkOutput("rst_parity", parity_out, 0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    out_ready = 1'b0;
    @(negedge clk);
    doReset();

    // Single beat latency.
    applyStimulus(1'b1, 4'b0001, 4'b0101, 2'b00, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1);
    checkOutput("t1_result", result, 4'b0001);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1);

    // Back-to-back stream of four ops.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b1111, 4'b1101, 2'(i), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1);
    checkOutput("t2_xfer_count", xfer_count, 4);

    // Backpressure: third beat refused until release.
    doReset();
    applyStimulus(1'b1, 4'b0011, 4'b0101, 2'b00, 1'b0);
    applyStimulus(1'b1, 4'b0011, 4'b0101, 2'b01, 1'b0);
    applyStimulus(1'b1, 4'b0011, 4'b0101, 2'b10, 1'b0);
    applyStimulus(1'b1, 4'b0011, 4'b0101, 2'b10, 1'b0);
    applyStimulus(1'b1, 4'b0011, 4'b0101, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1);

    // Zero flag and NAND boundary on complementary operands.
    applyStimulus(1'b1, 4'b1010, 4'b0101, 2'b00, 1'b1);
    applyStimulus(1'b1, 4'b1010, 4'b0101, 2'b11, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1);

    // Parity example beat.
    applyStimulus(1'b1, 4'b0111, 4'b0011, 2'b10, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1);

    // Reset with both stages full; nothing stale may emerge afterwards.
    applyStimulus(1'b1, 4'b1100, 4'b1010, 2'b01, 1'b0);
    applyStimulus(1'b1, 4'b1100, 4'b1010, 2'b10, 1'b0);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1);

    // Long stream to wrap the transfer counter.
    for (int i = 0; i < 262; i++)
      applyStimulus(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b1);

    // Random valid/ready traffic.
    for (int i = 0; i < 600; i++)
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 2'($urandom),
                    ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
